// File: rtl/act_packer.sv
// rtl/act_packer.sv - packs signed activations into PACK-lane words behind a small fall-through FIFO
module act_packer #(
  parameter int ACT_BITS   = 8,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ACT_BITS-1:0]      act_in,
  input  logic                     act_vld_in,
  input  logic                     flush,
  output logic [ACT_BITS*PACK-1:0] out_data,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic                     overflow,
  output logic                     busy
);

  localparam int OUT_BITS = ACT_BITS*PACK;
  localparam int LW       = $clog2(PACK);
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int CW       = PW + 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(PACK-1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  logic [PACK-1:0][ACT_BITS-1:0] pack_q, pack_d;
  logic [LW-1:0]                 lane_cnt, lane_nxt;
  logic                          push;
  logic [OUT_BITS-1:0]           push_word;

  logic [OUT_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                pop, full, push_ok;

  // Accept first, then flush sees the post-accept lane count so a completing
  // activation plus flush yields a single word.
  always_comb begin
    pack_d   = pack_q;
    lane_nxt = lane_cnt;
    push     = 1'b0;
    if (act_vld_in) begin
      pack_d[lane_cnt] = act_in;
      lane_nxt         = (lane_cnt == LAST_LANE) ? '0 : lane_cnt + 1'b1;
    end
    push_word = pack_d;
    if (act_vld_in && (lane_cnt == LAST_LANE)) begin
      push = 1'b1;
    end else if (flush && (lane_nxt != '0)) begin
      push = 1'b1;
    end
    if (push) begin
      pack_d   = '0;
      lane_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_q   <= '0;
      lane_cnt <= '0;
    end else begin
      pack_q   <= pack_d;
      lane_cnt <= lane_nxt;
    end
  end

  assign pop     = out_vld & out_rdy;
  assign full    = (count == FULL_CNT);
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push & ~push_ok) overflow <= 1'b1;
    end
  end

  // Storage is left unreset; the empty case is masked on the output instead.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  assign out_vld  = (count != '0);
  assign out_data = out_vld ? mem[rd_ptr] : '0;
  assign busy     = (lane_cnt != '0) | (count != '0);

endmodule
